uart_tx_gen: RTL and testbench

Parametrised UART transmitter, the next generation of the team's fixed-rate TX top. It accepts a parallel word on a valid/ready handshake and serialises it LSB-first as a start bit, data bits, optional parity and one or two stop bits. An internal bit-period prescaler sets the bit time. It drives the serial line of the UART block and sits between the system-side data source and the TX pad.

---
 rtl/uart_tx_gen.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_gen.sv
// uart_tx_gen: parametrised UART transmitter.
// Accepts a word on a DATA_VALID/DATA_READY handshake and sends it LSB-first.
// The frame is a start bit, DATA_WIDTH data bits, an optional parity bit and
// one or two stop bits. Each bit lasts PRESCALE+1 clock cycles.
// Optional feature: define UART_TX_GEN_HOLD_EN to add a one-entry hold
// register. A word accepted mid-frame then follows the current frame with no
// idle cycle between them.
module uart_tx_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  output logic                      DATA_READY,
  output logic                      S_DATA,
  output logic                      BUSY
);

  // Data-bit counter width. The data word is zero-padded to 2**CNT_W bits,
  // so any counter value is a legal index into it.
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int PAD_W = 1 << CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity is the XOR of the data bits. Odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  odd);
    return (^d) ^ odd;
  endfunction

  // Control state.
  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] timer;
  logic [CNT_W-1:0]          bit_cnt;
  logic                      stop_cnt;
  logic                      s_data_r;
  logic                      busy_r;

  // Frame register: the word and settings captured at acceptance.
  logic [DATA_WIDTH-1:0]     frm_data;
  logic                      frm_par_en;
  logic                      frm_par_typ;
  logic                      frm_stop2;
  logic [PRESCALE_WIDTH-1:0] frm_prescale;

  logic [PAD_W-1:0]          data_pad;
  logic [CNT_W-1:0]          next_cnt;
  logic                      bit_done;
  logic                      frame_end;
  logic                      accept;
  logic                      start_from_in;
  logic                      start_from_hold;
  logic [PRESCALE_WIDTH-1:0] start_prescale;

`ifdef UART_TX_GEN_HOLD_EN
  logic                      hold_full;
  logic [DATA_WIDTH-1:0]     hold_data;
  logic                      hold_par_en;
  logic                      hold_par_typ;
  logic                      hold_stop2;
  logic [PRESCALE_WIDTH-1:0] hold_prescale;
  logic                      load_hold;
`endif

  // The current bit ends when the down-counter has reached zero.
  assign bit_done  = (timer == '0);
  // The last cycle of the last stop bit.
  assign frame_end = (state == STOP) && bit_done && (!frm_stop2 || stop_cnt);
  assign next_cnt  = bit_cnt + CNT_W'(1);
  assign data_pad  = PAD_W'(frm_data);
  assign accept    = DATA_VALID && DATA_READY;

`ifdef UART_TX_GEN_HOLD_EN
  // Ready while idle or while the hold slot is free. A word accepted on the
  // final stop cycle with the slot empty goes straight into the frame
  // register, so a held word is never left waiting in IDLE.
  assign DATA_READY      = (state == IDLE) || !hold_full;
  assign start_from_hold = frame_end && hold_full;
  assign start_from_in   = accept && ((state == IDLE) || (frame_end && !hold_full));
  assign load_hold       = accept && !start_from_in;
  assign start_prescale  = start_from_hold ? hold_prescale : PRESCALE;
`else
  assign DATA_READY      = (state == IDLE);
  assign start_from_hold = 1'b0;
  assign start_from_in   = accept;
  assign start_prescale  = PRESCALE;
`endif

  assign S_DATA = s_data_r;
  assign BUSY   = busy_r;

  // Capture frame settings when a frame starts, from the inputs or from the hold slot.
  always_ff @(posedge CLK) begin
    if (start_from_in) begin
      frm_data     <= P_DATA;
      frm_par_en   <= PAR_EN;
      frm_par_typ  <= PAR_TYP;
      frm_stop2    <= STOP2;
      frm_prescale <= PRESCALE;
    end
`ifdef UART_TX_GEN_HOLD_EN
    else if (start_from_hold) begin
      frm_data     <= hold_data;
      frm_par_en   <= hold_par_en;
      frm_par_typ  <= hold_par_typ;
      frm_stop2    <= hold_stop2;
      frm_prescale <= hold_prescale;
    end
`endif
  end

`ifdef UART_TX_GEN_HOLD_EN
  // Park a word, with its settings, that was accepted while a frame is on the line.
  always_ff @(posedge CLK) begin
    if (load_hold) begin
      hold_data     <= P_DATA;
      hold_par_en   <= PAR_EN;
      hold_par_typ  <= PAR_TYP;
      hold_stop2    <= STOP2;
      hold_prescale <= PRESCALE;
    end
  end

  // Track hold-slot occupancy. A reset discards any parked word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_full <= 1'b0;
    end else if (load_hold) begin
      hold_full <= 1'b1;
    end else if (start_from_hold) begin
      hold_full <= 1'b0;
    end
  end
`endif

  // Frame sequencer: state, bit timer, bit counters and registered line outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      s_data_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_from_in) begin
            state    <= START;
            timer    <= start_prescale;
            s_data_r <= 1'b0;
            busy_r   <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            state    <= DATA;
            timer    <= frm_prescale;
            bit_cnt  <= '0;
            s_data_r <= frm_data[0];
          end else begin
            timer <= timer - PRESCALE_WIDTH'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            timer <= frm_prescale;
            if (bit_cnt == LAST_CNT) begin
              bit_cnt <= '0;
              if (frm_par_en) begin
                state    <= PARITY;
                s_data_r <= parity_bit(frm_data, frm_par_typ);
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                s_data_r <= 1'b1;
              end
            end else begin
              bit_cnt  <= next_cnt;
              s_data_r <= data_pad[next_cnt];
            end
          end else begin
            timer <= timer - PRESCALE_WIDTH'(1);
          end
        end

        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            timer    <= frm_prescale;
            stop_cnt <= 1'b0;
            s_data_r <= 1'b1;
          end else begin
            timer <= timer - PRESCALE_WIDTH'(1);
          end
        end

        STOP: begin
          if (frame_end) begin
            stop_cnt <= 1'b0;
            if (start_from_hold || start_from_in) begin
              // The next word starts immediately and BUSY stays high.
              state    <= START;
              timer    <= start_prescale;
              s_data_r <= 1'b0;
            end else begin
              state    <= IDLE;
              timer    <= '0;
              s_data_r <= 1'b1;
              busy_r   <= 1'b0;
            end
          end else if (bit_done) begin
            // The first of two stop bits is done. Time the second one.
            stop_cnt <= 1'b1;
            timer    <= frm_prescale;
          end else begin
            timer <= timer - PRESCALE_WIDTH'(1);
          end
        end

        default: begin
          state    <= IDLE;
          timer    <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          s_data_r <= 1'b1;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb_uart_tx_gen: self-checking bench for uart_tx_gen.
// The reference model expands every accepted word into its sequence of
// per-cycle line samples and queues them. The expected line is the head of
// that queue, or idle-high when the queue is empty.
`timescale 1ns/1ps
module tb_uart_tx_gen;
  localparam int W  = 8;
  localparam int PW = 16;
`ifdef UART_TX_GEN_HOLD_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic [PW-1:0] PRESCALE = '0;
  logic [W-1:0]  P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          DATA_READY;
  logic          S_DATA;
  logic          BUSY;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  uart_tx_gen #(.DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .S_DATA(S_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit q_line[$];
  bit q_start[$];
  bit fbits[$];
  bit exp_line = 1'b1;
  bit exp_busy = 1'b0;
  int waiting  = 0;   // accepted words whose first sample is not yet on the line

  // Bit sequence of one frame: start, data LSB first, optional parity, stops.
  function automatic void build_frame(input logic [W-1:0] d, input logic pe,
                                      input logic pt, input logic s2);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < W; i++) fbits.push_back(d[i]);
    if (pe) fbits.push_back((^d) ^ pt);
    fbits.push_back(1'b1);
    if (s2) fbits.push_back(1'b1);
  endfunction

  function automatic bit exp_ready();
`ifdef UART_TX_GEN_HOLD_EN
    return !exp_busy || (waiting == 0);
`else
    return !exp_busy;
`endif
  endfunction

  // Model update at each rising edge.
  initial forever begin
    @(posedge CLK);
    if (RST) begin
      q_line.delete();
      q_start.delete();
      waiting  = 0;
      exp_line = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (DATA_VALID && exp_ready()) begin
        build_frame(P_DATA, PAR_EN, PAR_TYP, STOP2);
        foreach (fbits[i])
          for (int r = 0; r <= int'(PRESCALE); r++) begin
            q_line.push_back(fbits[i]);
            q_start.push_back(i == 0 && r == 0);
          end
        waiting++;
      end
      if (q_line.size() > 0) begin
        exp_line = q_line.pop_front();
        if (q_start.pop_front()) waiting--;
        exp_busy = 1'b1;
      end else begin
        exp_line = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  // Compare DUT against the model at every falling edge.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      check("model_s_data", S_DATA, exp_line);
      check("model_busy", BUSY, exp_busy);
      check("model_ready", DATA_READY, exp_ready());
    end
  end

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic offer(input logic [W-1:0] d, input logic pe, input logic pt,
                       input logic s2, input logic [PW-1:0] ps);
    bit r;
    bit ok = 1'b0;
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = ps;
    DATA_VALID = 1'b1;
    for (int n = 0; n < 200; n++) begin
      r = DATA_READY;
      @(posedge CLK);
      if (r) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL handshake: no acceptance within 200 cycles, got 0 expected 1");
    end
  endtask

  task automatic capture(input int n, input int chg_at, input logic [PW-1:0] new_ps,
                         output logic [63:0] line, output int bcnt);
    line = '1;
    bcnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      if (k == 0) DATA_VALID = 1'b0;
      if (k == chg_at) PRESCALE = new_ps;
      line[k] = S_DATA;
      bcnt += int'(BUSY);
    end
  endtask

  task automatic pulse_reset();
    #2 RST = 1'b1;
    #1;
    check("async_rst_s_data", S_DATA, 1'b1);
    check("async_rst_busy", BUSY, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    DATA_VALID = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [63:0] line;
  int          bcnt;
  logic [9:0]  v;
  bit          bt[30];
  int          first, last, gap, total;
  bit          rdy_prev;

  initial begin
    // Pin the model against hand-computed frames.
    build_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) v[i] = fbits[i];
    check("model_a5_len", fbits.size(), 10);
    check("model_a5_bits", v, 10'h34A);
    build_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check("model_a5_odd_len", fbits.size(), 12);
    check("model_a5_odd_par", fbits[9], 1'b1);

    // Reset, then 20 quiet cycles.
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      check("idle_s_data", S_DATA, 1'b1);
      check("idle_busy", BUSY, 1'b0);
      check("idle_ready", DATA_READY, 1'b1);
    end

    // 0xA5, 8N1, one cycle per bit.
    offer(8'hA5, 1'b0, 1'b0, 1'b0, 16'd0);
    capture(12, -1, 16'd0, line, bcnt);
    check("a5_bits", line[9:0], 10'h34A);
    check("a5_after_stop", line[11:10], 2'b11);
    check("a5_busy_cycles", bcnt, 10);

    // Even parity, one stop bit.
    offer(8'hA5, 1'b1, 1'b0, 1'b0, 16'd0);
    capture(14, -1, 16'd0, line, bcnt);
    check("a5_even_par", line[9], 1'b0);
    check("a5_even_busy", bcnt, 11);

    // Odd parity, two stop bits.
    offer(8'hA5, 1'b1, 1'b1, 1'b1, 16'd0);
    capture(14, -1, 16'd0, line, bcnt);
    check("a5_odd_par", line[9], 1'b1);
    check("a5_odd_stops", line[11:10], 2'b11);
    check("a5_odd_busy", bcnt, 12);

    // PRESCALE=3 with a mid-frame change to 7.
    offer(8'h01, 1'b0, 1'b0, 1'b0, 16'd3);
    capture(44, 3, 16'd7, line, bcnt);
    check("ps3_busy", bcnt, 40);
    check("ps3_start_end", line[3], 1'b0);
    check("ps3_d0_first", line[4], 1'b1);
    check("ps3_d0_last", line[7], 1'b1);
    check("ps3_d1_first", line[8], 1'b0);
    check("ps3_d7_last", line[35], 1'b0);
    check("ps3_stop", line[39:36], 4'hF);
    check("ps3_idle_after", line[40], 1'b1);

    // Reset in the fourth data bit, then a clean frame.
    offer(8'hA5, 1'b0, 1'b0, 1'b0, 16'd3);
    capture(17, -1, 16'd0, line, bcnt);
    check("pre_rst_d3", line[16], 1'b0);
    pulse_reset();
    @(negedge CLK);
    check("post_rst_ready", DATA_READY, 1'b1);
    offer(8'hA5, 1'b0, 1'b0, 1'b0, 16'd0);
    capture(12, -1, 16'd0, line, bcnt);
    check("post_rst_bits", line[9:0], 10'h34A);
    check("post_rst_busy", bcnt, 10);

    // Back-to-back words 0x3C then 0xC3.
    offer(8'h3C, 1'b0, 1'b0, 1'b0, 16'd0);
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge CLK);
          bt[k] = BUSY;
        end
      end
      begin
        offer(8'hC3, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge CLK);
        DATA_VALID = 1'b0;
      end
    join
    first = -1; last = -1; gap = 0; total = 0;
    for (int k = 0; k < 30; k++)
      if (bt[k]) begin
        if (first < 0) first = k;
        last = k;
        total++;
      end
    if (first >= 0)
      for (int k = first; k <= last; k++)
        if (!bt[k]) gap++;
    check("b2b_gap", gap, EXP_GAP);
    check("b2b_busy_total", total, 20);

    // Randomised traffic with occasional mid-frame resets.
    repeat (12) @(negedge CLK);
    rdy_prev = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if (c % 1300 == 1299) begin
        pulse_reset();
        rdy_prev = 1'b0;
      end else begin
        if (DATA_VALID && rdy_prev) DATA_VALID = 1'b0;
        if (!DATA_VALID) begin
          PAR_EN   = 1'($urandom_range(0, 1));
          PAR_TYP  = 1'($urandom_range(0, 1));
          STOP2    = 1'($urandom_range(0, 1));
          PRESCALE = PW'($urandom_range(0, 3));
          if ($urandom_range(0, 2) == 0) begin
            P_DATA     = W'($urandom);
            DATA_VALID = 1'b1;
          end
        end
        rdy_prev = DATA_READY;
      end
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (120) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
